// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 fetch constants, status encoding and D record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {
        SAOK = 2'd0,
        SHLT = 2'd1,
        SADR = 2'd2,
        SINS = 2'd3
    } stat_e;

    typedef struct packed {
        stat_e       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_rec_t;

    localparam d_rec_t D_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'd0,
        valp:  64'd0
    };

endpackage

`default_nettype wire

// File: rtl/y86_instr_split.sv
// ============================================================================
// Module      : y86_instr_split
// Description : Combinational instruction split, length, valC and status
//               from a 10-byte fetch window and its per-byte valid mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_instr_split
    import y86_pkg::*;
(
    input  logic [79:0] i_window,
    input  logic [9:0]  i_valid,
    output logic [3:0]  o_icode,
    output logic [3:0]  o_ifun,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [63:0] o_valc,
    output logic [3:0]  o_len,
    output stat_e       o_stat
);

    logic       w_has_reg;
    logic       w_ifun_ok;
    logic       w_adr;
    logic       w_ins;
    logic [9:0] w_need;

    always_comb begin
        o_icode   = i_window[7:4];
        o_ifun    = i_window[3:0];
        o_valc    = 64'd0;
        o_len     = 4'd1;
        w_has_reg = 1'b0;
        w_ifun_ok = (o_ifun == 4'h0);

        case (o_icode)
            IHALT, INOP, IRET: o_len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                o_len     = 4'd2;
                w_has_reg = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                o_len     = 4'd10;
                w_has_reg = 1'b1;
                o_valc    = i_window[79:16];
            end
            IJXX, ICALL: begin
                o_len  = 4'd9;
                o_valc = i_window[71:8];
            end
            default: o_len = 4'd1;
        endcase

        if (o_icode == IRRMOVQ || o_icode == IJXX) begin
            w_ifun_ok = (o_ifun <= 4'd6);
        end else if (o_icode == IOPQ) begin
            w_ifun_ok = (o_ifun <= 4'd3);
        end

        o_ra = w_has_reg ? i_window[15:12] : RNONE;
        o_rb = w_has_reg ? i_window[11:8]  : RNONE;

        // Only bytes inside the instruction's own length can raise ADR.
        w_need = 10'((11'd1 << o_len) - 11'd1);
        w_adr  = |(w_need & ~i_valid);
        w_ins  = (o_icode > IPOPQ) || !w_ifun_ok;

        if (w_adr) begin
            o_stat = SADR;
        end else if (w_ins) begin
            o_stat = SINS;
        end else if (o_icode == IHALT) begin
            o_stat = SHLT;
        end else begin
            o_stat = SAOK;
        end
    end

endmodule

`default_nettype wire

// File: rtl/y86_fetch_pipe.sv
// ============================================================================
// Module      : y86_fetch_pipe
// Description : Y86-64 PIPE fetch stage: PC select, predicted-PC register F,
//               D pipeline register with stall/bubble and halt handling.
//               Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_fetch_pipe
    import y86_pkg::*;
#(
    parameter int          MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter string       INIT_FILE = "imem.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        M_mispredict,
    input  logic [63:0] M_valA,
    input  logic        W_ret,
    input  logic [63:0] W_valM,
    output logic [63:0] f_predPC,
    output logic [1:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stall
`endif
);

    localparam int          c_aw        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] c_mem_bytes = 64'(MEM_BYTES);

    logic [7:0] r_mem [MEM_BYTES];

    logic [63:0] w_pc_sel;
    logic [79:0] w_window;
    logic [9:0]  w_valid;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_len;
    logic [63:0] w_valc;
    logic [63:0] w_valp;
    logic [63:0] w_pred_next;
    stat_e       w_stat;
    d_rec_t      w_fetch_rec;

    logic [63:0] r_pred_pc_q;
    logic [63:0] w_pred_pc_d;
    d_rec_t      r_d_q;
    d_rec_t      w_d_d;
    logic        r_halted_q;
    logic        w_halted_d;
    logic        w_halt_eff;
    logic        w_d_load;

    always_comb begin
        w_pc_sel = r_pred_pc_q;
        if (M_mispredict) begin
            w_pc_sel = M_valA;
        end else if (W_ret) begin
            w_pc_sel = W_valM;
        end
    end

    // Bytes beyond the memory read as zero and are flagged invalid.
    for (genvar k = 0; k < 10; k++) begin : g_win
        logic [63:0] w_addr;
        assign w_addr             = w_pc_sel + 64'(k);
        assign w_valid[k]         = (w_addr < c_mem_bytes);
        assign w_window[8*k +: 8] = w_valid[k] ? r_mem[w_addr[c_aw-1:0]] : 8'h00;
    end

    y86_instr_split u_split (
        .i_window (w_window),
        .i_valid  (w_valid),
        .o_icode  (w_icode),
        .o_ifun   (w_ifun),
        .o_ra     (w_ra),
        .o_rb     (w_rb),
        .o_valc   (w_valc),
        .o_len    (w_len),
        .o_stat   (w_stat)
    );

    always_comb begin
        w_valp      = w_pc_sel + {60'd0, w_len};
        w_pred_next = (w_icode == IJXX || w_icode == ICALL) ? w_valc : w_valp;

        w_fetch_rec.stat  = w_stat;
        w_fetch_rec.icode = (w_stat == SAOK) ? w_icode : INOP;
        w_fetch_rec.ifun  = w_ifun;
        w_fetch_rec.ra    = w_ra;
        w_fetch_rec.rb    = w_rb;
        w_fetch_rec.valc  = w_valc;
        w_fetch_rec.valp  = w_valp;

        // A mispredict releases the halt in the same cycle it arrives.
        w_halt_eff = r_halted_q && !M_mispredict;
        w_d_load   = !D_stall && !D_bubble && !w_halt_eff;

        w_pred_pc_d = r_pred_pc_q;
        if (!F_stall && !w_halt_eff) begin
            w_pred_pc_d = w_pred_next;
        end

        w_d_d = r_d_q;
        if (!D_stall) begin
            w_d_d = (D_bubble || w_halt_eff) ? D_BUBBLE : w_fetch_rec;
        end

        w_halted_d = w_halt_eff || (w_d_load && w_stat != SAOK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc_q <= RESET_PC;
            r_d_q       <= D_BUBBLE;
            r_halted_q  <= 1'b0;
        end else begin
            r_pred_pc_q <= w_pred_pc_d;
            r_d_q       <= w_d_d;
            r_halted_q  <= w_halted_d;
        end
    end

    assign f_predPC = r_pred_pc_q;
    assign D_stat   = r_d_q.stat;
    assign D_icode  = r_d_q.icode;
    assign D_ifun   = r_d_q.ifun;
    assign D_rA     = r_d_q.ra;
    assign D_rB     = r_d_q.rb;
    assign D_valC   = r_d_q.valc;
    assign D_valP   = r_d_q.valp;

`ifdef FETCH_PERF_EN
    logic [63:0] r_perf_fetched_q;
    logic [63:0] w_perf_fetched_d;
    logic [63:0] r_perf_stall_q;
    logic [63:0] w_perf_stall_d;

    always_comb begin
        w_perf_fetched_d = r_perf_fetched_q + ((w_d_load && w_stat == SAOK) ? 64'd1 : 64'd0);
        w_perf_stall_d   = r_perf_stall_q + ((F_stall || D_stall) ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched_q <= 64'd0;
            r_perf_stall_q   <= 64'd0;
        end else begin
            r_perf_fetched_q <= w_perf_fetched_d;
            r_perf_stall_q   <= w_perf_stall_d;
        end
    end

    assign perf_fetched = r_perf_fetched_q;
    assign perf_stall   = r_perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_fetch_pipe.sv
// ============================================================================
// Module      : tb_y86_fetch_pipe
// Description : Self-checking bench for y86_fetch_pipe: directed scenarios
//               followed by randomized control/program stimulus vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_fetch_pipe;

    localparam int MEM = 1024;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } drec_t;

    localparam drec_t BUB = '{stat: 2'd0, icode: 4'd1, ifun: 4'd0, ra: 4'hF,
                              rb: 4'hF, valc: 64'd0, valp: 64'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        F_stall, D_stall, D_bubble, M_mispredict, W_ret;
    logic [63:0] M_valA, W_valM;
    logic [63:0] f_predPC, D_valC, D_valP;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched, perf_stall;
`endif

    y86_fetch_pipe #(.MEM_BYTES(MEM), .RESET_PC(64'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .F_stall      (F_stall),
        .D_stall      (D_stall),
        .D_bubble     (D_bubble),
        .M_mispredict (M_mispredict),
        .M_valA       (M_valA),
        .W_ret        (W_ret),
        .W_valM       (W_valM),
        .f_predPC     (f_predPC),
        .D_stat       (D_stat),
        .D_icode      (D_icode),
        .D_ifun       (D_ifun),
        .D_rA         (D_rA),
        .D_rB         (D_rB),
        .D_valC       (D_valC),
        .D_valP       (D_valP)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: current and next
    logic [7:0]  m_mem [MEM];
    logic [63:0] m_pc, n_pc, m_pf, n_pf, m_ps, n_ps;
    drec_t       m_d, n_d;
    logic        m_halt, n_halt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic put_byte(input int a, input logic [7:0] v);
        if (a >= 0 && a < MEM) begin
            m_mem[a]     = v;
            dut.r_mem[a] = v;
        end
    endtask

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [63:0] a);
        if (a < 64'(MEM)) return m_mem[a[9:0]];
        return 8'h00;
    endfunction

    function automatic drec_t fetch_at(input logic [63:0] pc, output logic [63:0] pred);
        drec_t      r;
        logic [7:0] b [10];
        int         len, off;
        logic       regs, hasc, adr, ifok;
        for (int k = 0; k < 10; k++) b[k] = rd(pc + 64'(k));
        r.icode = b[0][7:4];
        r.ifun  = b[0][3:0];
        len     = ilen(r.icode);
        regs    = r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        hasc    = r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        off     = regs ? 2 : 1;
        r.valc  = 64'd0;
        if (hasc) for (int i = 0; i < 8; i++) r.valc |= {56'd0, b[off+i]} << (8 * i);
        r.ra    = regs ? b[1][7:4] : 4'hF;
        r.rb    = regs ? b[1][3:0] : 4'hF;
        adr     = 1'b0;
        for (int k = 0; k < len; k++) if ((pc + 64'(k)) >= 64'(MEM)) adr = 1'b1;
        if (r.icode == 4'h2 || r.icode == 4'h7) ifok = (r.ifun <= 4'd6);
        else if (r.icode == 4'h6)               ifok = (r.ifun <= 4'd3);
        else                                    ifok = (r.ifun == 4'd0);
        if (adr)                              r.stat = 2'd2;
        else if (r.icode > 4'hB || !ifok)     r.stat = 2'd3;
        else if (r.icode == 4'h0)             r.stat = 2'd1;
        else                                  r.stat = 2'd0;
        r.valp = pc + 64'(len);
        pred   = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
        if (r.stat != 2'd0) r.icode = 4'h1;
        return r;
    endfunction

    function automatic void model_next();
        drec_t       f;
        logic [63:0] pc, pred;
        logic        heff, load;
        if (rst) begin
            n_pc = 64'd0; n_d = BUB; n_halt = 1'b0; n_pf = 64'd0; n_ps = 64'd0;
            return;
        end
        pc   = M_mispredict ? M_valA : (W_ret ? W_valM : m_pc);
        f    = fetch_at(pc, pred);
        heff = m_halt && !M_mispredict;
        load = !D_stall && !D_bubble && !heff;
        n_pc   = (F_stall || heff) ? m_pc : pred;
        n_d    = D_stall ? m_d : ((D_bubble || heff) ? BUB : f);
        n_halt = heff || (load && f.stat != 2'd0);
        n_pf   = m_pf + ((load && f.stat == 2'd0) ? 64'd1 : 64'd0);
        n_ps   = m_ps + ((F_stall || D_stall) ? 64'd1 : 64'd0);
    endfunction

    task automatic check_all();
        chk("f_predPC", f_predPC, m_pc);
        chk("D_stat", {62'd0, D_stat}, {62'd0, m_d.stat});
        chk("D_icode", {60'd0, D_icode}, {60'd0, m_d.icode});
        if (m_d.stat == 2'd0) begin
            chk("D_ifun", {60'd0, D_ifun}, {60'd0, m_d.ifun});
            chk("D_rA", {60'd0, D_rA}, {60'd0, m_d.ra});
            chk("D_rB", {60'd0, D_rB}, {60'd0, m_d.rb});
            chk("D_valC", D_valC, m_d.valc);
            chk("D_valP", D_valP, m_d.valp);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_pf);
        chk("perf_stall", perf_stall, m_ps);
`endif
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        m_pc = n_pc; m_d = n_d; m_halt = n_halt; m_pf = n_pf; m_ps = n_ps;
        check_all();
    endtask

    task automatic ctl(input logic r, input logic fs, input logic ds, input logic db,
                       input logic mp, input logic [63:0] va, input logic wr, input logic [63:0] vm);
        rst = r; F_stall = fs; D_stall = ds; D_bubble = db;
        M_mispredict = mp; M_valA = va; W_ret = wr; W_valM = vm;
    endtask

    task automatic gen_program();
        int a = 0;
        while (a < MEM) begin
            logic [7:0]  b [10];
            logic [3:0]  ic, fn;
            logic [63:0] vc;
            int          sel, len, off;
            sel = $urandom_range(0, 99);
            if (sel < 3) begin
                ic = 4'h0; fn = 4'h0;
            end else if (sel < 8) begin
                {ic, fn} = 8'($urandom);
            end else begin
                ic = 4'($urandom_range(1, 11));
                if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
                else if (ic == 4'h6)          fn = 4'($urandom_range(0, 3));
                else                          fn = 4'h0;
            end
            len  = ilen(ic);
            b[0] = {ic, fn};
            for (int k = 1; k < 10; k++) b[k] = 8'($urandom);
            if (ic == 4'h7 || ic == 4'h8) begin
                vc  = 64'($urandom_range(0, MEM + 15));
                off = 1;
                for (int i = 0; i < 8; i++) b[off+i] = vc[8*i +: 8];
            end
            for (int k = 0; k < len; k++) put_byte(a + k, b[k]);
            a += len;
        end
    endtask

    initial begin
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        m_pc = 64'd0; m_d = BUB; m_halt = 1'b0; m_pf = 64'd0; m_ps = 64'd0;
        #1;
        for (int i = 0; i < MEM; i++) put_byte(i, 8'h10);

        // irmovq $10, %rdx at 0 with two reset cycles
        put_byte(0, 8'h30); put_byte(1, 8'hF2); put_byte(2, 8'h0A);
        for (int i = 3; i < 10; i++) put_byte(i, 8'h00);
        step();
        step();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        chk("irmovq icode", {60'd0, D_icode}, 64'd3);
        chk("irmovq rA", {60'd0, D_rA}, 64'hF);
        chk("irmovq rB", {60'd0, D_rB}, 64'd2);
        chk("irmovq valC", D_valC, 64'd10);
        chk("irmovq valP", D_valP, 64'd10);

        // jmp 0x20 at 0
        put_byte(0, 8'h70); put_byte(1, 8'h20);
        for (int i = 2; i < 9; i++) put_byte(i, 8'h00);
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        chk("jmp predPC", f_predPC, 64'h20);
        chk("jmp valP", D_valP, 64'd9);
        chk("jmp valC", D_valC, 64'h20);

        // Mispredict beats ret
        put_byte(32'h40, 8'h60); put_byte(32'h41, 8'h12);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h40, 1'b1, 64'h80);
        step();
        chk("mispredict icode", {60'd0, D_icode}, 64'd6);
        chk("mispredict valP", D_valP, 64'h42);

        // Stall F and D for 3 cycles, then bubble
        ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (3) step();
        chk("stall held valP", D_valP, 64'h42);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        chk("bubble icode", {60'd0, D_icode}, 64'd1);
        chk("bubble rA", {60'd0, D_rA}, 64'hF);

        // irmovq straddling the end of memory -> ADR and halt
        put_byte(MEM - 2, 8'h30); put_byte(MEM - 1, 8'hF2);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'(MEM - 2), 1'b0, 64'd0);
        step();
        chk("adr stat", {62'd0, D_stat}, 64'd2);
        chk("adr icode", {60'd0, D_icode}, 64'd1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (3) step();
        chk("halted predPC frozen", f_predPC, 64'(MEM + 8));
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 64'd0);
        step();
        chk("resume icode", {60'd0, D_icode}, 64'd7);
        chk("resume stat", {62'd0, D_stat}, 64'd0);

        // INS / HLT / INS (rrmovq ifun 7)
        put_byte(32'h100, 8'hC0);
        put_byte(32'h110, 8'h00);
        put_byte(32'h120, 8'h27); put_byte(32'h121, 8'h12);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 64'd0);
        step();
        chk("byte C0 stat", {62'd0, D_stat}, 64'd3);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h110, 1'b0, 64'd0);
        step();
        chk("byte 00 stat", {62'd0, D_stat}, 64'd1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (2) step();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h120, 1'b0, 64'd0);
        step();
        chk("byte 27 stat", {62'd0, D_stat}, 64'd3);

        // 5 AOK fetches then 3 stall cycles
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (5) step();
        ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (3) step();
`ifdef FETCH_PERF_EN
        chk("perf_fetched=5", perf_fetched, 64'd5);
        chk("perf_stall=3", perf_stall, 64'd3);
`endif

        // Randomized program and control
        gen_program();
        ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        step();
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            F_stall      = ($urandom_range(0, 7) == 0);
            D_stall      = ($urandom_range(0, 7) == 0);
            D_bubble     = ($urandom_range(0, 7) == 0);
            M_mispredict = ($urandom_range(0, m_halt ? 3 : 15) == 0);
            M_valA       = 64'($urandom_range(0, MEM + 15));
            W_ret        = ($urandom_range(0, 11) == 0);
            W_valM       = 64'($urandom_range(0, MEM + 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
